// File: rtl/otter_pipe_pkg.sv
// Shared types for the OTTER 5-stage pipeline: forwarding select encoding,
// base opcodes and the register-match helper used by the hazard logic.
package otter_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    // EX, MEM and WB can each hold a pending register write
    localparam int NUM_SRC_STAGES = 3;

    // x0 is never a real dependency, so a zero destination never matches
    function automatic logic rd_match(input logic [4:0] rs, input logic rs_used,
                                      input logic [4:0] rd, input logic dst_live);
        return rs_used && dst_live && (rd != 5'd0) && (rs == rd);
    endfunction

endpackage

// File: rtl/otter_fwd_unit.sv
// EX-stage operand forwarding comparators; MEM result takes precedence over WB.
// With en low both selects fall back to the register file path.
module otter_fwd_unit
    import otter_pipe_pkg::*;
(
    input  logic       en,
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic [4:0] mem_rd,
    input  logic       mem_live,
    input  logic [4:0] wb_rd,
    input  logic       wb_live,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel
);

    logic [1:0][4:0] rs;
    logic [1:0][1:0] sel_bus;

    assign rs[0] = ex_rs1;
    assign rs[1] = ex_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            fwd_sel_t sel;

            always_comb begin
                sel = FWD_RF;
                if (en) begin
                    if (rd_match(rs[gi], 1'b1, mem_rd, mem_live)) begin
                        sel = FWD_MEM;
                    end else if (rd_match(rs[gi], 1'b1, wb_rd, wb_live)) begin
                        sel = FWD_WB;
                    end
                end
            end

            assign sel_bus[gi] = sel;
        end
    endgenerate

    assign fwd_a_sel = sel_bus[0];
    assign fwd_b_sel = sel_bus[1];

endmodule

// File: rtl/otter_hazard_ctrl.sv
// OTTER pipeline controller: stage valid bits, stall/flush control, forwarding
// selects and saturating stall/flush counters. OTTER_FORWARDING_EN enables
// forwarding; without it every RAW dependency stalls until written back.
module otter_hazard_ctrl
    import otter_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_pc_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_busy,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    output logic             stall_pc,
    output logic             stall_if,
    output logic             stall_de,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             if_de_valid,
    output logic             de_ex_valid,
    output logic             ex_mem_valid,
    output logic             mem_wb_valid,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic redirect;
    logic load_use;
    logic hazard;
    logic stall_front;
    logic stall_back;

    assign redirect = ex_pc_redirect & de_ex_valid;

    assign load_use = if_de_valid & de_ex_valid & ex_mem_read &
                      (rd_match(de_rs1, de_rs1_used, ex_rd, 1'b1) |
                       rd_match(de_rs2, de_rs2_used, ex_rd, 1'b1));

`ifdef OTTER_FORWARDING_EN
    localparam logic FWD_ON = 1'b1;

    assign hazard = load_use;
`else
    localparam logic FWD_ON = 1'b0;

    logic [4:0]                src_rd [NUM_SRC_STAGES];
    logic [NUM_SRC_STAGES-1:0] src_live;
    logic [NUM_SRC_STAGES-1:0] src_hit;

    assign src_rd[0]   = ex_rd;
    assign src_rd[1]   = mem_rd;
    assign src_rd[2]   = wb_rd;
    assign src_live[0] = de_ex_valid  & ex_reg_write;
    assign src_live[1] = ex_mem_valid & mem_reg_write;
    assign src_live[2] = mem_wb_valid & wb_reg_write;

    // WB is included: the register file does not bypass its own write port
    generate
        for (genvar gi = 0; gi < NUM_SRC_STAGES; gi++) begin : g_src
            assign src_hit[gi] = rd_match(de_rs1, de_rs1_used, src_rd[gi], src_live[gi]) |
                                 rd_match(de_rs2, de_rs2_used, src_rd[gi], src_live[gi]);
        end
    endgenerate

    // load_use is a subset of the RAW check for any load that writes a register
    assign hazard = (if_de_valid & (|src_hit)) | load_use;
`endif

    always_comb begin
        stall_front = 1'b0;
        stall_back  = 1'b0;
        if (!RESET) begin
            if (mem_busy) begin
                stall_front = 1'b1;
                stall_back  = 1'b1;
            end else if (!redirect && hazard) begin
                stall_front = 1'b1;
            end
        end
    end

    assign stall_pc  = stall_front;
    assign stall_if  = stall_front;
    assign stall_de  = stall_front;
    assign stall_ex  = stall_back;
    assign stall_mem = stall_back;

    otter_fwd_unit u_fwd (
        .en        (FWD_ON & ~RESET),
        .ex_rs1    (ex_rs1),
        .ex_rs2    (ex_rs2),
        .mem_rd    (mem_rd),
        .mem_live  (ex_mem_valid & mem_reg_write),
        .wb_rd     (wb_rd),
        .wb_live   (mem_wb_valid & wb_reg_write),
        .fwd_a_sel (fwd_a_sel),
        .fwd_b_sel (fwd_b_sel)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            if_de_valid  <= 1'b0;
            de_ex_valid  <= 1'b0;
            ex_mem_valid <= 1'b0;
            mem_wb_valid <= 1'b0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            // A redirect seen while frozen is simply re-evaluated once EX moves
            if (mem_busy) begin
                mem_wb_valid <= 1'b0;
            end else if (redirect) begin
                if_de_valid  <= 1'b0;
                de_ex_valid  <= 1'b0;
                ex_mem_valid <= de_ex_valid;
                mem_wb_valid <= ex_mem_valid;
            end else if (hazard) begin
                de_ex_valid  <= 1'b0;
                ex_mem_valid <= de_ex_valid;
                mem_wb_valid <= ex_mem_valid;
            end else begin
                if_de_valid  <= 1'b1;
                de_ex_valid  <= if_de_valid;
                ex_mem_valid <= de_ex_valid;
                mem_wb_valid <= ex_mem_valid;
            end

            if (stall_front && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (!mem_busy && redirect && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
